// File: rtl/ccd_frame_sequencer_if.sv
// ccd_frame_sequencer_if
//   Control, status and reader-handshake bundle for the linear-CCD frame
//   sequencer.
//   master : controller/reader side. Drives start, stop, continuous,
//            int_time and readall_samples. Observes the sensor timing and
//            status outputs.
//   slave  : sequencer side. Drives reader_enable, sh_pulse, sh_pulse_rise,
//            sh_pulse_fall, ccd_pulse, busy, frame_done, frame_count and
//            timeout_err.
interface ccd_frame_sequencer_if #(
  parameter int INT_W = 16
);
  logic             start;
  logic             stop;
  logic             continuous;
  logic [INT_W-1:0] int_time;
  logic             readall_samples;
  logic             reader_enable;
  logic             sh_pulse;
  logic             sh_pulse_rise;
  logic             sh_pulse_fall;
  logic             ccd_pulse;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frame_count;
  logic             timeout_err;

  modport master (
    output start, stop, continuous, int_time, readall_samples,
    input  reader_enable, sh_pulse, sh_pulse_rise, sh_pulse_fall, ccd_pulse,
           busy, frame_done, frame_count, timeout_err
  );

  modport slave (
    input  start, stop, continuous, int_time, readall_samples,
    output reader_enable, sh_pulse, sh_pulse_rise, sh_pulse_fall, ccd_pulse,
           busy, frame_done, frame_count, timeout_err
  );
endinterface

// File: rtl/ccd_frame_sequencer.sv
// ccd_frame_sequencer
//   Timing controller for the linear-CCD readout path. It drives the SH gate,
//   one ccd_pulse per pixel period and the reader enable. It also frames the
//   reader's sample stream with SH rise/fall strobes. Acquisition is single
//   shot or continuous. Each frame reads NUM_PIXELS pixel periods, followed by
//   int_time extra periods of integration.
// Ports
//   clk   : system clock
//   rst_n : asynchronous active-low reset; release is expected synchronous
//           to clk
//   bus   : ccd_frame_sequencer_if.slave. Carries start/stop/continuous/
//           int_time/readall_samples in. Carries the sensor strobes, busy,
//           frame_done, frame_count and timeout_err out.
// Every output is a flop, so each strobe is decided one cycle before it
// becomes visible.
module ccd_frame_sequencer #(
  parameter int PIX_DIV    = 4,
  parameter int NUM_PIXELS = 2048,
  parameter int SH_WIDTH   = 8,
  parameter int INT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ccd_frame_sequencer_if.slave  bus
);
  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int SH_W  = $clog2(SH_WIDTH);
  localparam int PIX_W = 17;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(PIX_DIV - 2);
  localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(SH_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SH_HI, EXPOSE} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [SH_W-1:0]  sh_cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic [INT_W-1:0] int_lat;
  logic             first_frame, stop_pending, acked;
  logic             sh_q, rise_q, fall_q, ccd_q, en_q, busy_q, done_q, to_q;
  logic [15:0]      cnt_q;

  logic [PIX_W-1:0] frame_len;
  logic             accept, sh_end, last_frame, pix_end;

  assign frame_len  = PIX_W'(NUM_PIXELS) + PIX_W'(int_lat);
  // The first SH_HI after start carries no frame, so no ack is expected there.
  assign accept     = (state == SH_HI) && !first_frame && !acked && bus.readall_samples;
  assign sh_end     = (state == SH_HI) && (sh_cnt == SH_LAST);
  assign last_frame = !first_frame && (stop_pending || !bus.continuous);
  assign pix_end    = (pix_cnt + PIX_W'(1)) == frame_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      sh_cnt       <= '0;
      pix_cnt      <= '0;
      int_lat      <= '0;
      first_frame  <= 1'b0;
      stop_pending <= 1'b0;
      acked        <= 1'b0;
      sh_q         <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      ccd_q        <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      to_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      ccd_q  <= 1'b0;
      done_q <= accept;
      if (accept) begin
        cnt_q <= cnt_q + 16'd1;
        acked <= 1'b1;
      end
      if (state != IDLE && bus.stop) stop_pending <= 1'b1;

      case (state)
        IDLE: if (bus.start) begin
          state        <= SH_HI;
          sh_cnt       <= '0;
          sh_q         <= 1'b1;
          rise_q       <= 1'b1;
          en_q         <= 1'b1;
          busy_q       <= 1'b1;
          cnt_q        <= '0;
          to_q         <= 1'b0;
          first_frame  <= 1'b1;
          acked        <= 1'b0;
          stop_pending <= bus.stop;
        end
        SH_HI: begin
          sh_cnt <= sh_cnt + SH_W'(1);
          if (sh_end) begin
            // An ack arriving in this very cycle still counts as seen.
            if (!first_frame && !acked && !accept) to_q <= 1'b1;
            first_frame <= 1'b0;
            sh_q        <= 1'b0;
            if (last_frame) begin
              state        <= IDLE;
              en_q         <= 1'b0;
              busy_q       <= 1'b0;
              stop_pending <= 1'b0;
            end else begin
              state   <= EXPOSE;
              fall_q  <= 1'b1;
              int_lat <= bus.int_time;
              div_cnt <= '0;
              pix_cnt <= '0;
            end
          end
        end
        EXPOSE: begin
          div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
          // The strobe is registered, so it is raised while the divider
          // sits one count short of the period end.
          ccd_q   <= (div_cnt == DIV_PRE);
          if (div_cnt == DIV_LAST) begin
            pix_cnt <= pix_cnt + PIX_W'(1);
            if (pix_end) begin
              state  <= SH_HI;
              sh_cnt <= '0;
              sh_q   <= 1'b1;
              rise_q <= 1'b1;
              acked  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sh_pulse      = sh_q;
  assign bus.sh_pulse_rise = rise_q;
  assign bus.sh_pulse_fall = fall_q;
  assign bus.ccd_pulse     = ccd_q;
  assign bus.reader_enable = en_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;
  assign bus.frame_count   = cnt_q;
  assign bus.timeout_err   = to_q;
endmodule

// File: tb/tb_ccd_frame_sequencer.sv
// tb_ccd_frame_sequencer
//   Bench for ccd_frame_sequencer with PIX_DIV=4, NUM_PIXELS=16, SH_WIDTH=8.
//   Cycle c means the interval that starts at posedge c. Inputs are driven
//   1 time unit after that edge, and outputs are sampled on the following
//   negedge.
module tb_ccd_frame_sequencer;
  localparam int PIX_DIV = 4, NUM_PIXELS = 16, SH_WIDTH = 8, INT_W = 16;
  localparam int MAXC = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccd_frame_sequencer_if #(.INT_W(INT_W)) bus ();

  ccd_frame_sequencer #(
    .PIX_DIV(PIX_DIV), .NUM_PIXELS(NUM_PIXELS), .SH_WIDTH(SH_WIDTH), .INT_W(INT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic sh, rise, fall, ccd, busy, en, fd, to;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    int   cyc;
    logic start, ack;
    obs_t exp;
  } vec_t;

  int checks = 0, passes = 0;

  task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.sh   = bus.sh_pulse;      o.rise = bus.sh_pulse_rise;
    o.fall = bus.sh_pulse_fall; o.ccd  = bus.ccd_pulse;
    o.busy = bus.busy;          o.en   = bus.reader_enable;
    o.fd   = bus.frame_done;    o.to   = bus.timeout_err;
    o.cnt  = bus.frame_count;
    return o;
  endfunction

  function automatic obs_t mko(input logic sh, rise, fall, ccd, busy, fd, to, input int cnt);
    obs_t o;
    o.sh = sh; o.rise = rise; o.fall = fall; o.ccd = ccd;
    o.busy = busy; o.en = busy; o.fd = fd; o.to = to; o.cnt = 16'(cnt);
    return o;
  endfunction

  function automatic vec_t mk(input int cyc, input logic st, ak, sh, rise, fall, ccd, busy, fd, to, input int cnt);
    vec_t v;
    v.cyc = cyc; v.start = st; v.ack = ak;
    v.exp = mko(sh, rise, fall, ccd, busy, fd, to, cnt);
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.stop = 1'b0; bus.continuous = 1'b0;
    bus.int_time = '0; bus.readall_samples = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Directed continuous run. It records fall-strobe cycles, the pulses of
  // each frame, and the frame_count seen at each frame_done. The ack is
  // given one cycle after every rise strobe.
  int   fall_c[$], pul[$], fd_cnt[$];
  int   to_c;
  obs_t last_o;

  task automatic run_seq(input int ncyc, input int it0, input int it1, input int sw_c,
                         input int stop_c, input int xs_c, input logic ack_en);
    int   p;
    logic ack_next;
    fall_c.delete(); pul.delete(); fd_cnt.delete();
    p = 0; ack_next = 1'b0; to_c = -1;
    for (int c = 0; c < ncyc; c++) begin
      next_cycle();
      bus.start           = (c == 0) || (c == xs_c);
      bus.stop            = (c == stop_c);
      bus.continuous      = 1'b1;
      bus.int_time        = (c < sw_c) ? INT_W'(it0) : INT_W'(it1);
      bus.readall_samples = ack_en && ack_next;
      @(negedge clk);
      last_o   = sample();
      ack_next = last_o.rise;
      if (last_o.ccd) p++;
      if (last_o.fall) begin
        if (fall_c.size() > 0) pul.push_back(p);
        p = 0;
        fall_c.push_back(c);
      end
      if (last_o.fd) fd_cnt.push_back(int'(last_o.cnt));
      if (last_o.to && to_c < 0) to_c = c;
    end
    if (fall_c.size() > 0) pul.push_back(p);
    idle_inputs();
  endtask

  // Random-run stimulus and the expected waveform derived frame by frame.
  logic st[MAXC], cn[MAXC], ak[MAXC];
  int   it[MAXC];
  int   stop_c;
  obs_t ex[MAXC];

  task automatic build_model(output int bend);
    int   t, e, acc, len, to_from, idx, n;
    logic first, last, done;
    int   inc_c[$];
    for (int c = 0; c < MAXC; c++) ex[c] = '0;
    t = 1; first = 1'b1; done = 1'b0; to_from = MAXC; bend = MAXC - 1;
    while (!done) begin
      e = t + SH_WIDTH - 1;
      for (int c = t; c <= e; c++) ex[c].sh = 1'b1;
      ex[t].rise = 1'b1;
      if (!first) begin
        acc = -1;
        for (int a = t; a <= e; a++) if (ak[a] && acc < 0) acc = a;
        if (acc >= 0) begin
          ex[acc+1].fd = 1'b1;
          inc_c.push_back(acc + 1);
        end else if (to_from == MAXC) to_from = e + 1;
      end
      last = !first && ((stop_c < e) || !cn[e]);
      if (last) begin
        bend = e;
        done = 1'b1;
      end else begin
        ex[e+1].fall = 1'b1;
        len = NUM_PIXELS + it[e];
        for (int j = 0; j < len; j++) begin
          idx = e + 1 + PIX_DIV * j + PIX_DIV - 1;
          if (idx < MAXC) ex[idx].ccd = 1'b1;
        end
        t = e + 1 + len * PIX_DIV;
        first = 1'b0;
        if (t + SH_WIDTH + 1 >= MAXC) done = 1'b1;
      end
    end
    for (int c = 1; c <= bend; c++) begin
      ex[c].busy = 1'b1;
      ex[c].en   = 1'b1;
    end
    for (int c = 0; c < MAXC; c++) begin
      n = 0;
      foreach (inc_c[k]) if (inc_c[k] <= c) n++;
      ex[c].cnt = 16'(n);
      ex[c].to  = (c >= to_from);
    end
  endtask

  initial begin
    vec_t tv[$];
    obs_t o;
    int   npulse, bend;

    // T1: single-shot frame, checked against a cycle table.
    do_reset();
    @(negedge clk);
    chk("reset_state", 0, 64'(sample()), 64'(obs_t'('0)));
    //            cyc st ak sh ri fa cc bs fd to cnt
    tv.push_back(mk( 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk( 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk( 2, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk( 8, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk( 9, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tv.push_back(mk(10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(12, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(13, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(72, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(73, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(74, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(75, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1));
    tv.push_back(mk(76, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1));
    tv.push_back(mk(80, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1));
    tv.push_back(mk(81, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tv.push_back(mk(84, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    npulse = 0;
    for (int c = 0; c < 86; c++) begin
      next_cycle();
      bus.start = 1'b0; bus.readall_samples = 1'b0;
      foreach (tv[i]) if (tv[i].cyc == c) begin
        bus.start = tv[i].start;
        bus.readall_samples = tv[i].ack;
      end
      @(negedge clk);
      o = sample();
      if (o.ccd) npulse++;
      foreach (tv[i]) if (tv[i].cyc == c) chk($sformatf("t1_c%0d", c), c, 64'(o), 64'(tv[i].exp));
    end
    chk("t1_pulses", 86, 64'(npulse), 64'(16));

    // T2/T3: continuous with int_time=4, stop mid-EXPOSE of the fourth frame.
    do_reset();
    run_seq(400, 4, 4, 0, 300, -1, 1'b1);
    chk("t3_falls", 400, 64'(fall_c.size()), 64'(4));
    chk("t2_period1", 400, 64'(fall_c[1] - fall_c[0]), 64'(88));
    chk("t2_period2", 400, 64'(fall_c[2] - fall_c[1]), 64'(88));
    for (int k = 0; k < 4; k++) chk($sformatf("t2_pulses%0d", k), 400, 64'(pul[k]), 64'(20));
    chk("t2_fd_n", 400, 64'(fd_cnt.size()), 64'(4));
    for (int k = 0; k < 4; k++) chk($sformatf("t2_count%0d", k), 400, 64'(fd_cnt[k]), 64'(k + 1));
    chk("t3_end", 400, 64'(last_o), 64'(mko(0, 0, 0, 0, 0, 0, 0, 4)));

    // T4: no ack ever; timeout at end of the 2nd SH_HI, frames continue.
    do_reset();
    run_seq(200, 0, 0, 0, 100, -1, 1'b0);
    chk("t4_to_cycle", 200, 64'(to_c), 64'(81));
    chk("t4_fall2", 200, 64'(fall_c[1]), 64'(81));
    chk("t4_end", 200, 64'(last_o), 64'(mko(0, 0, 0, 0, 0, 0, 1, 0)));
    next_cycle(); bus.start = 1'b1;
    @(negedge clk);
    next_cycle(); bus.start = 1'b0;
    @(negedge clk);
    chk("t4_restart", 202, 64'(sample()), 64'(mko(1, 1, 0, 0, 1, 0, 0, 0)));

    // T5: reset mid-EXPOSE, then restart.
    do_reset();
    run_seq(30, 0, 0, 0, -1, -1, 1'b1);
    chk("t5_busy_before", 29, 64'(last_o.busy), 64'(1));
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("t5_async", 30, 64'(sample()), 64'(obs_t'('0)));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_released", 32, 64'(sample()), 64'(obs_t'('0)));
    next_cycle(); bus.start = 1'b1;
    @(negedge clk);
    next_cycle(); bus.start = 1'b0;
    @(negedge clk);
    chk("t5_restart", 34, 64'(sample()), 64'(mko(1, 1, 0, 0, 1, 0, 0, 0)));

    // T6: int_time 0->8 mid-frame, stray start while busy.
    do_reset();
    run_seq(300, 0, 8, 30, 200, 90, 1'b1);
    chk("t6_falls", 300, 64'(fall_c.size()), 64'(3));
    chk("t6_pulses0", 300, 64'(pul[0]), 64'(16));
    chk("t6_pulses1", 300, 64'(pul[1]), 64'(24));
    chk("t6_period1", 300, 64'(fall_c[1] - fall_c[0]), 64'(72));
    chk("t6_period2", 300, 64'(fall_c[2] - fall_c[1]), 64'(104));
    chk("t6_fd_n", 300, 64'(fd_cnt.size()), 64'(3));
    chk("t6_count2", 300, 64'(fd_cnt[1]), 64'(2));
    chk("t6_end", 300, 64'(last_o), 64'(mko(0, 0, 0, 0, 0, 0, 0, 3)));

    // Randomized runs against the frame-level model.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < MAXC; c++) begin
        st[c] = 1'b0;
        ak[c] = ($urandom_range(0, 5) == 0);
        it[c] = int'($urandom_range(0, 7));
      end
      begin
        int drop;
        drop = int'($urandom_range(50, 700));
        for (int c = 0; c < MAXC; c++) cn[c] = (c < drop);
      end
      stop_c = int'($urandom_range(0, 700));
      st[0] = 1'b1;
      build_model(bend);
      for (int k = 0; k < 3; k++) st[$urandom_range(1, bend)] = 1'b1;
      do_reset();
      for (int c = 0; c < MAXC; c++) begin
        next_cycle();
        bus.start           = st[c];
        bus.stop            = (c == stop_c);
        bus.continuous      = cn[c];
        bus.int_time        = INT_W'(it[c]);
        bus.readall_samples = ak[c];
        @(negedge clk);
        chk($sformatf("rand%0d", r), c, 64'(sample()), 64'(ex[c]));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
